rib_mem_slave: RTL and testbench
================================

Name: rib_mem_slave

Overview:
Responder end of the core's data-memory bus. It accepts the level-held read and write requests the core issues, converts them into req/gnt/rvalid transactions on a synchronous SRAM port, returns read data, and drives the RIB hold flag that stalls the core while an access is outstanding. A per-transaction watchdog terminates SRAM accesses that never answer.

Parameters:
ADDR_W, 32, byte address width (matches MEM_ADDR_BUS)
DATA_W, 32, data width (matches MEM_DATA_BUS)
TIMEOUT_CYC, 256, max cycles waiting for gnt or rvalid; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
mem_rib_rreq_i  in  1  core read request, level, held while hold=1
mem_raddr_i  in  ADDR_W  read address
mem_rib_wreq_i  in  1  core write request, level
mem_wen_i  in  1  write enable; write only when wreq&&wen
mem_waddr_i  in  ADDR_W  write address
mem_wdata_i  in  DATA_W  write data
mem_rdata_o  out  DATA_W  read data, registered
rib_hold_flag_o  out  1  stall the core
bus_err_o  out  1  one-cycle pulse on watchdog expiry
sram_req_o  out  1  SRAM request, held until gnt
sram_we_o  out  1  1=write
sram_addr_o  out  ADDR_W  SRAM byte address, passed through unmodified
sram_wdata_o  out  DATA_W  SRAM write data
sram_gnt_i  in  1  SRAM accepted request
sram_rvalid_i  in  1  read data valid, at least 1 cycle after gnt
sram_rdata_i  in  DATA_W  SRAM read data

Behaviour:
- Clock clk_i; rst_i is asynchronous, active-high. Reset forces state=IDLE, all outputs 0, mem_rdata_o=0, watchdog=0, captured request flags cleared.
- States: IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE.
- IDLE: if wreq&&wen or rreq, latch the addresses, wdata and pending flags (wr_pend, rd_pend). Go to WR_REQ if wr_pend, else RD_REQ.
- Write has priority. When both requests are present, the write completes first, then the read; hold stays asserted throughout.
- WR_REQ: sram_req_o=1, we=1, addr=waddr. On gnt, go to RD_REQ if rd_pend, else DONE.
- RD_REQ: req=1, we=0, addr=raddr. On gnt, go to RD_WAIT. If rvalid arrives in the same cycle as gnt, ignore it; SRAM protocol forbids this.
- RD_WAIT: on rvalid, mem_rdata_o <= sram_rdata_i, then go to DONE.
- DONE: one cycle with hold=0, during which the core advances. Requests seen in DONE are ignored (they are the stale, already-served request). Then go to IDLE.
- rib_hold_flag_o = (IDLE && (rreq || (wreq && wen))) || state in {WR_REQ, RD_REQ, RD_WAIT}. This is combinational, so the core stalls in the request cycle.
- Minimum latency: read is 4 cycles (IDLE, RD_REQ, RD_WAIT, DONE) with gnt at once and rvalid the next cycle. Write is 3 cycles.
- mem_rdata_o holds the last read value across writes and idle cycles.
- wreq with wen=0 is ignored; no SRAM access and no hold.
- Watchdog: counts cycles in WR_REQ, RD_REQ and RD_WAIT, and clears on every state change.
  - At TIMEOUT_CYC: drop req, mem_rdata_o <= 32'hDEAD_BEEF (for a read), pulse bus_err_o, go to DONE.
  - A pending read after a timed-out write is abandoned.
- A reset asserted mid-transaction aborts immediately with no SRAM handshake completion. The SRAM owner must tolerate a dropped req.

Optional Feature:
RIB_POSTED_WR_EN.
- Defined: single-entry write buffer.
  - A write-only request in IDLE with the buffer empty is captured without hold (hold=0 that cycle) and drained by WR_REQ in the background.
  - Any new request while the buffer is full holds until the drain finishes.
  - A read with a write in the same cycle: buffer the write, then drain it before the read; ordering is preserved.
  - A write timeout still pulses bus_err_o.
- Undefined: every write is non-posted, exactly as above.

Decomposition:
- Package rib_pkg: state enum rib_slv_state_e, RIB_ERR_DATA = 32'hDEAD_BEEF, default ADDR_W/DATA_W.
- One sub-module, rib_wdog_cnt: counter with clear, enable and expire outputs, parameterised by TIMEOUT_CYC, where 0 means never expire.

Test Plan:
- Read 0x0000_0100, SRAM gnt at once, rvalid 1 cycle later with 0x1234_5678 -> hold=1 for 3 cycles, then DONE with mem_rdata_o=0x1234_5678, hold=0.
- Write 0x200/0xCAFE_F00D, gnt delayed 3 cycles -> sram_req_o held 4 cycles with we=1 and stable addr/data; hold released in DONE; mem_rdata_o unchanged.
- rreq 0x300 and wreq 0x304 in the same cycle -> SRAM sees the write to 0x304 first, then the read to 0x300; a single DONE cycle.
- TIMEOUT_CYC=8, read with no gnt -> after 8 cycles req drops, bus_err_o=1 for 1 cycle, mem_rdata_o=0xDEAD_BEEF, hold=0.
- rst_i asserted in RD_WAIT -> next edge-independent: sram_req_o=0, hold=0, mem_rdata_o=0; a subsequent read completes normally.
- With RIB_POSTED_WR_EN: write 0x400 then read 0x400 the next cycle, SRAM returns the written value -> no hold on the write; the read holds until the drain finishes and returns the posted data.

Source files
------------

// File: rtl/rib_pkg.sv
// Shared types and constants for the RIB data-memory responder.
package rib_pkg;

    localparam int unsigned RIB_ADDR_W   = 32;
    localparam int unsigned RIB_DATA_W   = 32;
    localparam logic [31:0] RIB_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DONE
    } rib_slv_state_e;

endpackage

// File: rtl/rib_wdog_cnt.sv
// Per-transaction watchdog: counts enabled cycles, expires on the TIMEOUT_CYC-th one.
// TIMEOUT_CYC = 0 never expires.
module rib_wdog_cnt #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/rib_mem_slave.sv
// RIB data-memory responder: core level requests -> SRAM req/gnt/rvalid, with hold and watchdog.
// Optional build macro RIB_POSTED_WR_EN enables a single-entry posted write buffer.
module rib_mem_slave
    import rib_pkg::*;
#(
    parameter int unsigned ADDR_W      = RIB_ADDR_W,
    parameter int unsigned DATA_W      = RIB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_rib_rreq_i,
    input  logic [ADDR_W-1:0] mem_raddr_i,
    input  logic              mem_rib_wreq_i,
    input  logic              mem_wen_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              rib_hold_flag_o,
    output logic              bus_err_o,
    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic              sram_gnt_i,
    input  logic              sram_rvalid_i,
    input  logic [DATA_W-1:0] sram_rdata_i
);

`ifdef RIB_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    rib_slv_state_e    state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              rd_pend_q, rd_pend_d;
    logic              err_q, err_d;
    logic              posted_q, posted_d;
    logic              wr_req, any_req, wd_en, wd_expire;
    rib_slv_state_e    wr_end;

    assign wr_req  = mem_rib_wreq_i && mem_wen_i;
    assign any_req = wr_req || mem_rib_rreq_i;
    assign wd_en   = state_q inside {ST_WR_REQ, ST_RD_REQ, ST_RD_WAIT};
    // A posted drain returns straight to IDLE: the core already advanced when it was captured.
    assign wr_end  = posted_q ? ST_IDLE : ST_DONE;

    rib_wdog_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_d != state_q),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            waddr_q   <= '0;
            raddr_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            posted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            raddr_q   <= raddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
            posted_q  <= posted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        raddr_d   = raddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rd_pend_d = rd_pend_q;
        posted_d  = posted_q;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                posted_d = POSTED && wr_req && !mem_rib_rreq_i;
                if (any_req) begin
                    waddr_d   = mem_waddr_i;
                    wdata_d   = mem_wdata_i;
                    raddr_d   = mem_raddr_i;
                    rd_pend_d = mem_rib_rreq_i;
                    state_d   = wr_req ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (sram_gnt_i) begin
                    state_d = rd_pend_q ? ST_RD_REQ : wr_end;
                end else if (wd_expire) begin
                    rd_pend_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = wr_end;
                end
            end
            ST_RD_REQ: begin
                if (sram_gnt_i) begin
                    state_d = ST_RD_WAIT;
                end else if (wd_expire) begin
                    rdata_d = DATA_W'(RIB_ERR_DATA);
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_WAIT: begin
                if (sram_rvalid_i) begin
                    rdata_d = sram_rdata_i;
                    state_d = ST_DONE;
                end else if (wd_expire) begin
                    rdata_d = DATA_W'(RIB_ERR_DATA);
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sram_req_o      = 1'b0;
        sram_we_o       = 1'b0;
        sram_addr_o     = '0;
        sram_wdata_o    = '0;
        rib_hold_flag_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rib_hold_flag_o = POSTED ? mem_rib_rreq_i : any_req;
            end
            ST_WR_REQ: begin
                sram_req_o      = 1'b1;
                sram_we_o       = 1'b1;
                sram_addr_o     = waddr_q;
                sram_wdata_o    = wdata_q;
                rib_hold_flag_o = posted_q ? any_req : 1'b1;
            end
            ST_RD_REQ: begin
                sram_req_o      = 1'b1;
                sram_addr_o     = raddr_q;
                rib_hold_flag_o = 1'b1;
            end
            ST_RD_WAIT: begin
                rib_hold_flag_o = 1'b1;
            end
            default: begin
                rib_hold_flag_o = 1'b0;
            end
        endcase
    end

    assign mem_rdata_o = rdata_q;
    assign bus_err_o   = err_q;

endmodule

// File: tb/tb_rib_mem_slave.sv
// Scoreboard bench for rib_mem_slave: reactive SRAM responder, core driver and monitor.
module tb_rib_mem_slave;

    localparam int T = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        rreq, wreq, wen;
    logic [31:0] raddr, waddr, wdata;
    logic [31:0] rdata;
    logic        hold, bus_err;
    logic        sreq, swe;
    logic [31:0] saddr, swdata;
    logic        gnt, rvalid;
    logic [31:0] srdata;

    always #5 clk = ~clk;

    rib_mem_slave #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .mem_rib_rreq_i  (rreq),
        .mem_raddr_i     (raddr),
        .mem_rib_wreq_i  (wreq),
        .mem_wen_i       (wen),
        .mem_waddr_i     (waddr),
        .mem_wdata_i     (wdata),
        .mem_rdata_o     (rdata),
        .rib_hold_flag_o (hold),
        .bus_err_o       (bus_err),
        .sram_req_o      (sreq),
        .sram_we_o       (swe),
        .sram_addr_o     (saddr),
        .sram_wdata_o    (swdata),
        .sram_gnt_i      (gnt),
        .sram_rvalid_i   (rvalid),
        .sram_rdata_i    (srdata)
    );

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
    typedef struct { logic [31:0] rdata; bit err; int hold; } done_t;

    acc_t        exp_acc[$];
    done_t       exp_done[$];
    int          gq[$];
    int          rvq[$];
    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] rd_last = '0;
    bit          req_active = 1'b0;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] init_val(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SRAM model: gnt after a per-access delay, rvalid a per-read delay after gnt
    initial begin
        int cnt, d, rv_cnt;
        bit busy;
        logic [31:0] rv_data;
        cnt = 0; d = 0; rv_cnt = 0; busy = 0; rv_data = '0;
        gnt = 0; rvalid = 0; srdata = '0;
        forever begin
            @(posedge clk); #1;
            gnt = 0; rvalid = 0;
            if (rst) begin
                busy = 0; rv_cnt = 0; gq.delete(); rvq.delete();
                continue;
            end
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin rvalid = 1; srdata = rv_data; end
            end
            if (sreq) begin
                if (!busy) begin
                    busy = 1; cnt = 0; rv_cnt = 0;
                    d = (gq.size() > 0) ? gq.pop_front() : 1000;
                end
                if (cnt == d) begin
                    gnt = 1; busy = 0;
                    if (swe) sram_mem[saddr] = swdata;
                    else begin
                        rv_data = sram_mem.exists(saddr) ? sram_mem[saddr] : init_val(saddr);
                        rv_cnt  = (rvq.size() > 0) ? rvq.pop_front() : 1;
                    end
                end else cnt++;
            end else busy = 0;
        end
    end

    // Monitor: SRAM accesses and core-visible completions against the scoreboard
    initial begin
        int hc;
        acc_t ea;
        done_t ed;
        bit completion;
        hc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin hc = 0; continue; end
            if (sreq && gnt) begin
                if (exp_acc.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sram_access: unexpected we=%0b addr=%h", swe, saddr);
                end else begin
                    ea = exp_acc.pop_front();
                    check("sram_we", {31'b0, swe}, {31'b0, ea.we});
                    check("sram_addr", saddr, ea.addr);
                    if (ea.we) check("sram_wdata", swdata, ea.wdata);
                end
            end
            completion = req_active && !hold;
            if (bus_err && !completion) begin
                tests++; fails++;
                $display("FAIL stray_bus_err: got 1 expected 0");
            end
            if (req_active) begin
                if (hold) hc++;
                else begin
                    if (exp_done.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL completion: unexpected completion, rdata %h", rdata);
                    end else begin
                        ed = exp_done.pop_front();
                        check("mem_rdata", rdata, ed.rdata);
                        check("bus_err", {31'b0, bus_err}, {31'b0, ed.err});
                        check("hold_cycles", 32'(hc), 32'(ed.hold));
                    end
                    hc = 0;
                end
            end
        end
    end

    task automatic summary_and_finish();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // One core transaction; expectations derived from the access rules and chosen SRAM delays
    task automatic txn(bit rd, bit wr, bit we_v, logic [31:0] ra, logic [31:0] wa,
                       logic [31:0] wd, int wgd, int rgd, int rvd);
        bit wr_eff, err, abandon;
        int hc;
        logic [31:0] exp_rd;
        wr_eff = wr && we_v;
        hc = (wr_eff || rd) ? 1 : 0;
        err = 0; abandon = 0; exp_rd = rd_last;
        if (wr_eff) begin
            gq.push_back(wgd);
            if (wgd >= T) begin hc += T; err = 1; abandon = 1; end
            else begin
                hc += wgd + 1;
                exp_acc.push_back('{1'b1, wa, wd});
                ref_mem[wa] = wd;
            end
        end
        if (rd && !abandon) begin
            gq.push_back(rgd);
            if (rgd >= T) begin hc += T; err = 1; exp_rd = ERR_DATA; end
            else begin
                hc += rgd + 1;
                exp_acc.push_back('{1'b0, ra, 32'h0});
                rvq.push_back(rvd);
                if (rvd > T) begin hc += T; err = 1; exp_rd = ERR_DATA; end
                else begin
                    hc += rvd;
                    exp_rd = ref_mem.exists(ra) ? ref_mem[ra] : init_val(ra);
                end
            end
        end
        rd_last = exp_rd;
        exp_done.push_back('{exp_rd, err, hc});

        @(posedge clk); #1;
        rreq = rd; wreq = wr; wen = we_v; raddr = ra; waddr = wa; wdata = wd;
        req_active = 1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (!hold) break;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL hold_release: got hold stuck for %0d cycles expected release", n);
                summary_and_finish();
            end
        end
    endtask

    task automatic idle(int n);
        @(posedge clk); #1;
        rreq = 0; wreq = 0; wen = 0; req_active = 0;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int pick_gd();
        int r;
        r = $urandom_range(0, 11);
        if (r <= 7) return $urandom_range(0, 3);
        if (r <= 9) return T - 1;
        if (r == 10) return T;
        return T + 3;
    endfunction

    function automatic int pick_rvd();
        int r;
        r = $urandom_range(0, 11);
        if (r <= 8) return $urandom_range(1, 3);
        if (r == 9) return T;
        if (r == 10) return T + 1;
        return 1;
    endfunction

    function automatic logic [31:0] pick_addr();
        return 32'h1000 + {26'b0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    initial begin
        rst = 1; rreq = 0; wreq = 0; wen = 0; raddr = '0; waddr = '0; wdata = '0;
        sram_mem[32'h100] = 32'h1234_5678;
        ref_mem[32'h100]  = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_hold", {31'b0, hold}, 32'h0);
        check("rst_sram_req", {31'b0, sreq}, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        rst = 0;

        txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 0, 0, 1);
        idle(1);
        txn(0, 1, 1, 32'h0, 32'h200, 32'hCAFE_F00D, 3, 0, 1);
        idle(0);
        txn(1, 1, 1, 32'h300, 32'h304, 32'hA5A5_0304, 0, 0, 1);
        txn(1, 0, 0, 32'h304, 32'h0, 32'h0, 1, 0, 2);
        txn(1, 0, 0, 32'h100, 32'h0, 32'h0, T + 5, 0, 1);
        idle(2);
        txn(0, 1, 0, 32'h0, 32'h208, 32'h1111_2222, 0, 0, 1);
        txn(1, 1, 1, 32'h200, 32'h20C, 32'h3333_4444, T, 0, 1);
        idle(0);
        txn(1, 0, 0, 32'h200, 32'h0, 32'h0, T - 1, T, 1);
        txn(1, 0, 0, 32'h20C, 32'h0, 32'h0, 0, 0, T + 1);
        idle(3);

        // Reset while the read sits in RD_WAIT
        gq.push_back(0); rvq.push_back(50);
        exp_acc.push_back('{1'b0, 32'h500, 32'h0});
        @(posedge clk); #1;
        rreq = 1; raddr = 32'h500;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        rst = 1; rreq = 0;
        #1;
        check("arst_sram_req", {31'b0, sreq}, 32'h0);
        check("arst_hold", {31'b0, hold}, 32'h0);
        check("arst_rdata", rdata, 32'h0);
        check("arst_bus_err", {31'b0, bus_err}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 0; rd_last = '0;
        txn(1, 0, 0, 32'h304, 32'h0, 32'h0, 0, 0, 1);

        for (int i = 0; i < 60; i++) begin
            bit rd, wr, we_v;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            we_v = ($urandom_range(0, 5) != 0);
            txn(rd, wr, we_v, pick_addr(), pick_addr(), $urandom, pick_gd(), pick_gd(), pick_rvd());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
        end

        idle(4);
        check("acc_queue_drained", 32'(exp_acc.size()), 32'h0);
        check("done_queue_drained", 32'(exp_done.size()), 32'h0);
        summary_and_finish();
    end

endmodule
